seqgen_serial_tx: RTL and testbench
===================================

// Module: seqgen_serial_tx
// PURPOSE
//  Serial pattern transmitter: latches a PAT_W-bit pattern and shifts it out MSB-first,
//  one bit per clk, repeated repeat_n times with an optional idle gap between repetitions.
//  Drives the single-bit serial stream consumed by the team's Mealy/Moore sequence
//  detectors; used as the stimulus/line-driver end of that serial interface.
// PARAMETERS
//  PAT_W   4        pattern width in bits (>=2)
//  CNT_W   8        width of repeat_n and repetition counter
//  GAP_W   4        width of gap (idle cycles between repetitions)
// PORTS
//  clk       in   1      clock, all logic on posedge
//  rst       in   1      asynchronous, active-high reset
//  start     in   1      request; sampled only in IDLE
//  abort     in   1      synchronous abort of current transfer
//  pattern   in   PAT_W  pattern, latched on accepted start
//  repeat_n  in   CNT_W  repetitions, latched on accepted start
//  gap       in   GAP_W  idle cycles between repetitions, latched on accepted start
//  x         out  1      serial data (0 when x_valid=0)
//  x_valid   out  1      x carries a pattern bit this cycle
//  sof       out  1      x is the MSB (first bit) of a repetition
//  busy      out  1      transfer in progress (SHIFT or GAP)
//  done      out  1      one-cycle pulse: transfer completed normally
// BEHAVIOUR
//  - Moore FSM; every output is a registered function of state/datapath, none combinational from inputs.
//  - Reset (async, immediate): state=IDLE; x, x_valid, sof, busy, done = 0; counters/shreg = 0.
//  - States: IDLE, SHIFT, GAP, DONE.
//  - IDLE: start=1 & repeat_n!=0 -> SHIFT, latch pattern/repeat_n/gap; start=1 & repeat_n==0 -> DONE.
//  - Latency: start accepted at edge T -> first bit (MSB) on x from T+1, sof=1 that cycle.
//  - SHIFT: PAT_W cycles, x=pattern[PAT_W-1-i], i=0..PAT_W-1; x_valid=1; busy=1.
//    After bit i=PAT_W-1: reps left & gap!=0 -> GAP; reps left & gap==0 -> next rep back-to-back
//    (SHIFT, sof=1 next cycle); last rep -> DONE.
//  - GAP: exactly gap cycles, x=0, x_valid=0, busy=1; then SHIFT with sof=1.
//  - DONE: one cycle, done=1, busy=0, x_valid=0; -> IDLE. start in DONE ignored (not queued).
//  - start while busy ignored; pattern/repeat_n/gap changes while busy have no effect.
//  - abort=1 in SHIFT/GAP/DONE -> IDLE next edge, all outputs 0, no done pulse; abort in IDLE no-op;
//    abort has priority over start in the same cycle.
//  - Repetition counter counts down from latched repeat_n; no wrap (max 2^CNT_W-1 reps).
//  - Bit index counter width $clog2(PAT_W); terminal count PAT_W-1, non-power-of-2 PAT_W legal.
//  - Total cycles start->done = repeat_n*PAT_W + (repeat_n-1)*gap + 1.
// STRUCTURE
//  - Package seqgen_pkg: typedef enum logic [1:0] {IDLE,SHIFT,GAP,DONE} seqgen_state_t;
//    localparam default test pattern PAT_1010 = 4'b1010.
//  - One sub-module: seqgen_piso (parallel-in/serial-out shift register, load + shift enables,
//    MSB out); FSM, bit/rep/gap counters stay in the top module.
// TESTING
//  1 pattern=1010, repeat_n=1, gap=0, start 1 cycle -> x=1,0,1,0 on cycles T+1..T+4,
//    sof only at T+1, done at T+5, busy T+1..T+4.
//  2 pattern=1010, repeat_n=3, gap=0 -> 12 valid bits 101010101010, sof at T+1/T+5/T+9, done T+13.
//  3 pattern=1100, repeat_n=2, gap=3 -> 1100, 3 cycles x_valid=0 (busy=1), 1100, done T+12.
//  4 repeat_n=0 start -> no x_valid, done at T+1; start held high during transfer -> exactly one transfer.
//  5 abort asserted in 2nd bit of rep 2 (and abort+start same cycle in IDLE) -> IDLE next edge,
//    outputs 0, no done; new start afterwards transmits normally.
//  6 rst asserted asynchronously mid-SHIFT (between edges) -> outputs 0 immediately; PAT_W=5 run
//    of 10110 x2 checks non-power-of-2 index wrap.

Source files
------------

// File: rtl/seqgen_pkg.sv
// Shared types and constants for the serial pattern transmitter.
package seqgen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } seqgen_state_t;

  // Default pattern used by the sequence detectors' directed tests.
  localparam logic [3:0] PAT_1010 = 4'b1010;

endpackage

// File: rtl/seqgen_piso.sv
// Parallel-in/serial-out shift register. Load has priority over shift;
// shifting fills with zeros, so PAT_W shifts after a load leave it empty.
module seqgen_piso #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] din,
  output logic             msb
);

  logic [PAT_W-1:0] shreg;

  // Load a new word or shift toward the MSB, zero-filling from the LSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift) begin
      shreg <= {shreg[PAT_W-2:0], 1'b0};
    end
  end

  assign msb = shreg[PAT_W-1];

endmodule

// File: rtl/seqgen_serial_tx.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first,
// repeat_n times, with an optional idle gap between repetitions.
// The serial bit is taken straight from the shift register MSB, which is
// cleared whenever no pattern bit is being sent, so x is 0 outside SHIFT.
module seqgen_serial_tx
  import seqgen_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap,
  output logic             x,
  output logic             x_valid,
  output logic             sof,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  seqgen_state_t    state;
  logic [IDX_W-1:0] bit_idx;
  logic [CNT_W-1:0] rep_cnt;   // repetitions remaining, including the current one
  logic [GAP_W-1:0] gap_cnt;   // gap cycles remaining after the current one
  logic [PAT_W-1:0] pat_q;
  logic [GAP_W-1:0] gap_q;

  logic             piso_load;
  logic             piso_shift;
  logic [PAT_W-1:0] piso_din;
  logic             piso_msb;

  logic             last_bit;
  logic             more_reps;
  logic             accept;
  logic             kill;

  assign last_bit  = (bit_idx == LAST_IDX);
  assign more_reps = (rep_cnt > CNT_W'(1));
  assign accept    = (state == IDLE) && start && !abort;
  assign kill      = abort && (state != IDLE);

  // Shift register control: reload at the start of every repetition,
  // shift while sending, clear on abort.
  always_comb begin
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    piso_din   = pat_q;
    if (kill) begin
      piso_load = 1'b1;
      piso_din  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && (repeat_n != '0)) begin
            piso_load = 1'b1;
            piso_din  = pattern;
          end
        end
        SHIFT: begin
          if (last_bit && more_reps && (gap_q == '0)) begin
            piso_load = 1'b1;
          end else begin
            piso_shift = 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            piso_load = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  seqgen_piso #(
    .PAT_W (PAT_W)
  ) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (piso_load),
    .shift (piso_shift),
    .din   (piso_din),
    .msb   (piso_msb)
  );

  assign x = piso_msb;

  // Transfer FSM with counters and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_idx <= '0;
      rep_cnt <= '0;
      gap_cnt <= '0;
      pat_q   <= '0;
      gap_q   <= '0;
      x_valid <= 1'b0;
      sof     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (kill) begin
      state   <= IDLE;
      bit_idx <= '0;
      rep_cnt <= '0;
      gap_cnt <= '0;
      x_valid <= 1'b0;
      sof     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (repeat_n != '0) begin
              state   <= SHIFT;
              pat_q   <= pattern;
              rep_cnt <= repeat_n;
              gap_q   <= gap;
              bit_idx <= '0;
              x_valid <= 1'b1;
              sof     <= 1'b1;
              busy    <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        SHIFT: begin
          sof <= 1'b0;
          if (last_bit) begin
            bit_idx <= '0;
            if (more_reps) begin
              rep_cnt <= rep_cnt - CNT_W'(1);
              if (gap_q != '0) begin
                state   <= GAP;
                gap_cnt <= gap_q - GAP_W'(1);
                x_valid <= 1'b0;
              end else begin
                sof <= 1'b1;
              end
            end else begin
              state   <= DONE;
              rep_cnt <= '0;
              x_valid <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end else begin
            bit_idx <= bit_idx + IDX_W'(1);
          end
        end

        GAP: begin
          if (gap_cnt == '0) begin
            state   <= SHIFT;
            bit_idx <= '0;
            x_valid <= 1'b1;
            sof     <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seqgen_serial_tx.sv
// Directed bench for seqgen_serial_tx: a 4-bit and a 5-bit instance, with a
// per-cycle expected-output queue filled when a transfer is launched.
module tb_seqgen_serial_tx;
  import seqgen_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start4 = 1'b0, abort4 = 1'b0;
  logic [3:0] pattern4 = '0;
  logic [7:0] rep4 = '0;
  logic [3:0] gap4 = '0;
  logic       x4, xv4, sof4, busy4, done4;

  logic       start5 = 1'b0, abort5 = 1'b0;
  logic [4:0] pattern5 = '0;
  logic [7:0] rep5 = '0;
  logic [3:0] gap5 = '0;
  logic       x5, xv5, sof5, busy5, done5;

  int         checks = 0;
  int         errors = 0;
  logic [4:0] q[$];
  bit         sel = 1'b0;

  seqgen_serial_tx #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .abort(abort4), .pattern(pattern4),
    .repeat_n(rep4), .gap(gap4), .x(x4), .x_valid(xv4), .sof(sof4),
    .busy(busy4), .done(done4)
  );

  seqgen_serial_tx #(.PAT_W(5), .CNT_W(8), .GAP_W(4)) u5 (
    .clk(clk), .rst(rst), .start(start5), .abort(abort5), .pattern(pattern5),
    .repeat_n(rep5), .gap(gap5), .x(x5), .x_valid(xv5), .sof(sof5),
    .busy(busy5), .done(done5)
  );

  always #5 clk = ~clk;

  // Observed vector {x, x_valid, sof, busy, done} of the selected instance.
  function automatic logic [4:0] obs();
    return sel ? {x5, xv5, sof5, busy5, done5} : {x4, xv4, sof4, busy4, done4};
  endfunction

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, got, exp);
    end
  endtask

  // Expected per-cycle outputs from the cycle after acceptance onward.
  task automatic push_model(input logic [4:0] pat, input int n, input int g, input int pw);
    for (int r = 0; r < n; r++) begin
      for (int i = 0; i < pw; i++)
        q.push_back({pat[pw-1-i], 1'b1, (i == 0), 1'b1, 1'b0});
      if (r < n - 1)
        for (int k = 0; k < g; k++) q.push_back(5'b00010);
    end
    q.push_back(5'b00001);
    q.push_back(5'b00000);
  endtask

  // Request a transfer, then scramble the request inputs to show they are latched.
  task automatic launch(input bit s, input logic [4:0] pat, input int n, input int g,
                        input bit hold);
    sel = s;
    if (s) begin
      pattern5 = pat; rep5 = 8'(n); gap5 = 4'(g); start5 = 1'b1;
    end else begin
      pattern4 = pat[3:0]; rep4 = 8'(n); gap4 = 4'(g); start4 = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      start4 = 1'b0;
      start5 = 1'b0;
    end
    pattern4 = ~pattern4; pattern5 = ~pattern5;
    rep4 = 8'd7; rep5 = 8'd7; gap4 = 4'd9; gap5 = 4'd9;
    push_model(pat, n, g, s ? 5 : 4);
  endtask

  // Compare up to limit queued cycles (all of them when limit < 0).
  task automatic drain(input string tag, input int limit);
    int k = 0;
    while (q.size() > 0 && (limit < 0 || k < limit)) begin
      @(negedge clk);
      check(tag, obs(), q.pop_front());
      k++;
    end
  endtask

  initial begin
    #2;
    sel = 1'b0; check("reset_u4", obs(), 5'b00000);
    sel = 1'b1; check("reset_u5", obs(), 5'b00000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // single repetition
    launch(1'b0, 5'(PAT_1010), 1, 0, 1'b0);
    drain("t1_single", -1);

    // three back-to-back repetitions
    launch(1'b0, 5'(PAT_1010), 3, 0, 1'b0);
    drain("t2_b2b", -1);

    // two repetitions with a 3-cycle gap
    launch(1'b0, 5'b01100, 2, 3, 1'b0);
    drain("t3_gap", -1);

    // zero repetitions, then start held high for a whole transfer
    launch(1'b0, 5'b01010, 0, 0, 1'b0);
    drain("t4_zero", -1);
    launch(1'b0, 5'(PAT_1010), 1, 0, 1'b1);
    drain("t4_hold", -1);
    start4 = 1'b0;
    @(negedge clk);
    check("t4_hold_idle", obs(), 5'b00000);

    // abort during the 2nd bit of repetition 2
    launch(1'b0, 5'(PAT_1010), 3, 0, 1'b0);
    drain("t5_pre", 6);
    q.delete();
    abort4 = 1'b1;
    @(posedge clk);
    #1 abort4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_abort", obs(), 5'b00000);
    end
    // abort and start together in IDLE: start is dropped
    pattern4 = 4'b1111; rep4 = 8'd2; gap4 = 4'd0;
    start4 = 1'b1; abort4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0; abort4 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t5_abort_start", obs(), 5'b00000);
    end
    launch(1'b0, 5'b00110, 2, 1, 1'b0);
    drain("t5_after", -1);

    // asynchronous reset between edges mid-SHIFT
    launch(1'b0, 5'(PAT_1010), 2, 0, 1'b0);
    drain("t6_pre", 2);
    q.delete();
    #2 rst = 1'b1;
    #1 check("t6_async_rst", obs(), 5'b00000);
    @(posedge clk);
    #1 check("t6_rst_held", obs(), 5'b00000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst_idle", obs(), 5'b00000);

    // 5-bit pattern, index wrap at a non-power-of-2 width
    launch(1'b1, 5'b10110, 2, 0, 1'b0);
    drain("t6_p5_b2b", -1);
    launch(1'b1, 5'b10110, 2, 2, 1'b0);
    drain("t6_p5_gap", -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
